// File: rtl/mc_cpu_ctrl_hs.sv
// Multi-cycle CPU controller: sequences fetch/decode/execute over a req/ack memory
// port and drives the external register file, ALU and PSR; halts, resumes and traps.
//
// state | meaning
// IF    | fetch instruction at pc over the memory handshake
// ID    | decode, capture operands, resolve branches
// EXE   | capture ALU result
// MEM   | load/store data handshake
// WB    | one-cycle register/PSR write strobes
// HALT  | stopped until resume
// TRAP  | illegal opcode or bus timeout; left only through reset
module mc_cpu_ctrl_hs #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int RESET_PC    = 0,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        rf_raddr1,
  output logic [3:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W:0]   alu_result,
  output logic              psr_we,
  output logic [DATA_W:0]   psr_d,
  input  logic [4:0]        psr_q,
  input  logic              resume,
  output logic              halted,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [ADDR_W-1:0] pc
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [3:0] OP_NOP = 4'd0, OP_BRA = 4'd1, OP_LD  = 4'd2, OP_STR = 4'd3,
                         OP_ADD = 4'd4, OP_MUL = 4'd5, OP_CMP = 4'd6, OP_SHF = 4'd7,
                         OP_ROT = 4'd8, OP_HLT = 4'd9;

  typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB, S_HALT, S_TRAP} state_t;

  state_t            state;
  logic [31:0]       ir;
  logic [CNT_W-1:0]  wait_cnt;
  logic [3:0]        op;
  logic              imm;
  logic [DATA_W-1:0] imm_ext;
  logic              br_taken;
  logic              timeout_hit;

  assign op          = ir[31:28];
  assign imm         = ir[27];
  assign imm_ext     = {{(DATA_W-12){1'b0}}, ir[23:12]};
  // wait_cnt holds the number of unacknowledged req cycles already elapsed
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    br_taken = 1'b0;
    case (ir[27:24])
      4'd0:                         br_taken = 1'b1;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: br_taken = psr_q[ir[26:24] - 3'd1];
      default:                      br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IF;
      ir         <= '0;
      wait_cnt   <= '0;
      pc         <= ADDR_W'(RESET_PC);
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rf_raddr1  <= '0;
      rf_raddr2  <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      psr_we     <= 1'b0;
      psr_d      <= '0;
      halted     <= 1'b0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      rf_we  <= 1'b0;
      psr_we <= 1'b0;
      case (state)
        S_IF: begin
          if (!mem_req) begin
            // only after reset or a store, so requests are never back-to-back
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            wait_cnt  <= '0;
            ir        <= mem_rdata[31:0];
            rf_raddr1 <= mem_rdata[15:12];
            rf_raddr2 <= mem_rdata[3:0];
            rf_waddr  <= mem_rdata[3:0];
            pc        <= pc + ADDR_W'(1);
            state     <= S_ID;
          end else if (timeout_hit) begin
            mem_req    <= 1'b0;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
            state      <= S_TRAP;
          end else if (MEM_TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_ID: begin
          case (op)
            OP_NOP: begin
              mem_req  <= 1'b1;
              mem_addr <= pc;
              state    <= S_IF;
            end
            OP_BRA: begin
              mem_req  <= 1'b1;
              mem_addr <= br_taken ? ir[ADDR_W-1:0] : pc;
              if (br_taken) pc <= ir[ADDR_W-1:0];
              state    <= S_IF;
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            OP_LD: begin
              if (imm) begin
                rf_wdata <= imm_ext;
                psr_d    <= {1'b0, imm_ext};
                rf_we    <= 1'b1;
                psr_we   <= 1'b1;
                state    <= S_WB;
              end else begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= ir[12 +: ADDR_W];
                state    <= S_MEM;
              end
            end
            OP_STR: begin
              mem_wdata <= imm ? imm_ext : rf_rdata1;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= ir[ADDR_W-1:0];
              state     <= S_MEM;
            end
            OP_ADD, OP_MUL, OP_CMP, OP_SHF, OP_ROT: begin
              alu_a  <= imm ? imm_ext : rf_rdata1;
              alu_b  <= rf_rdata2;
              alu_op <= op;
              state  <= S_EXE;
            end
            default: begin
              trap       <= 1'b1;
              trap_cause <= 2'b01;
              state      <= S_TRAP;
            end
          endcase
        end
        S_EXE: begin
          rf_wdata <= alu_result[DATA_W-1:0];
          psr_d    <= alu_result;
          psr_we   <= 1'b1;
          rf_we    <= (op != OP_CMP);
          state    <= S_WB;
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wait_cnt <= '0;
            if (op == OP_LD) begin
              rf_wdata <= mem_rdata;
              psr_d    <= {1'b0, mem_rdata};
              rf_we    <= 1'b1;
              psr_we   <= 1'b1;
              state    <= S_WB;
            end else begin
              state <= S_IF;
            end
          end else if (timeout_hit) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
            state      <= S_TRAP;
          end else if (MEM_TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
          state    <= S_IF;
        end
        S_HALT: begin
          if (resume) begin
            halted   <= 1'b0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            state    <= S_IF;
          end
        end
        S_TRAP: state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

endmodule

// File: doc/mc_cpu_ctrl_hs.md
Name: mc_cpu_ctrl_hs

Overview:
- Next-generation multi-cycle CPU controller, parametrised in data width, address width, reset vector and memory timeout.
- Owns the PC and IR internally and drives the register file, ALU and PSR.
- Talks to memory over a req/ack handshake with wait states and a timeout.
- Adds conditional-branch evaluation, CMP without writeback, halt/resume, and an illegal-opcode/bus-error trap.

Parameters:
DATA_W, 32, datapath width; must be >= 32 (IR is mem_rdata[31:0]); immediates are zero-extended to DATA_W.
ADDR_W, 12, memory address and PC width; must be <= 12; addresses use the low ADDR_W bits of 12-bit fields.
RESET_PC, 0, PC value loaded on reset.
MEM_TIMEOUT, 255, max wait cycles for mem_ack before a bus trap; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle
mem_ack  in  1  transfer complete; ignored while mem_req=0
rf_raddr1  out  4  source-1 register address (ir[15:12])
rf_raddr2  out  4  source-2 register address (ir[3:0])
rf_rdata1  in  DATA_W  async read data, port 1
rf_rdata2  in  DATA_W  async read data, port 2
rf_we  out  1  register write strobe, 1 cycle
rf_waddr  out  4  write address (ir[3:0])
rf_wdata  out  DATA_W  write data
alu_op  out  4  ALU function (opcode)
alu_a  out  DATA_W  ALU operand 1
alu_b  out  DATA_W  ALU operand 2
alu_result  in  DATA_W+1  ALU result; MSB is carry
psr_we  out  1  PSR update strobe
psr_d  out  DATA_W+1  value from which the PSR derives flags
psr_q  in  5  flags {n,z,p,e,c} = bits [4:0]
resume  in  1  leaves HALT
halted  out  1  high in HALT
trap  out  1  sticky trap flag
trap_cause  out  2  01 = illegal opcode, 10 = bus timeout
pc  out  ADDR_W  current PC

Behaviour:
- Instruction fields: op = ir[31:28] (NOP 0, BRA 1, LD 2, STR 3, ADD 4, MUL 5, CMP 6, SHF 7, ROT 8, HLT 9; A-F are illegal). imm flag = ir[27]; cc = ir[27:24]; src1 imm/address = ir[23:12]; target/store address = ir[11:0]; dest = ir[3:0].
- States: IF, ID, EXE, MEM, WB, HALT, TRAP. All outputs are Moore/registered; there is no combinational path from any input to any output.
- Reset (reset=0): state=IF, pc=RESET_PC, ir=0, wait counter=0. mem_req, mem_we, rf_we, psr_we, halted, trap = 0; trap_cause=0; all data/address outputs = 0. Reset asserted mid-handshake drops mem_req immediately.
- IF: mem_req=1, mem_we=0, mem_addr=pc. On ack: ir<=mem_rdata[31:0], pc<=pc+1 (wraps mod 2^ADDR_W), go to ID.
- ID:
  - NOP -> IF.
  - HLT -> HALT.
  - Illegal opcode -> TRAP with cause 01.
  - BRA: taken if cc=0, or if cc in 1..5 and psr_q[cc-1]=1; cc 6-15 is never taken. If taken, pc<=ir[ADDR_W-1:0]. Go to IF.
  - LD imm: data<=zext(ir[23:12]), go to WB.
  - LD direct: go to MEM (read, addr = ir[23:12]).
  - STR: wdata<= imm ? zext(ir[23:12]) : rf_rdata1; go to MEM (write, addr = ir[11:0]).
  - ALU ops (4-8): alu_a<= imm ? zext(ir[23:12]) : rf_rdata1; alu_b<=rf_rdata2; alu_op<=op; go to EXE.
- EXE: result<=alu_result; go to WB.
- MEM: handshake identical to IF. On ack, LD latches mem_rdata and goes to WB; STR goes to IF.
- WB, one cycle, then IF:
  - LD: rf_we=1, psr_we=1, psr_d={1'b0,data}.
  - ADD/MUL/SHF/ROT: rf_we=1, psr_we=1, rf_wdata=result[DATA_W-1:0], psr_d=result.
  - CMP: psr_we=1 only; rf_we stays 0.
- Handshake: mem_req, mem_we, mem_addr and mem_wdata are stable from assertion through the ack cycle. mem_req deasserts in the cycle after ack, so there are no back-to-back requests. Ack in the first req cycle is legal (0 wait states).
- Timeout: the counter increments each req cycle without ack and clears on ack. If it reaches MEM_TIMEOUT and MEM_TIMEOUT != 0, go to TRAP with cause 10. An ack arriving in that same cycle wins.
- HALT: halted=1. resume=1 -> IF with pc unchanged.
- TRAP: trap=1, cause is held, all strobes are 0. Only reset exits TRAP.
- Latency (0 wait states): ALU op 5 cycles (IF 1, ID, EXE, WB, plus the IF-exit edge); BRA/NOP 2 cycles past fetch; LD-mem and STR add the MEM handshake.

Test Plan:
- Reset, then mem returns 0x4000_0003 (ADD r0+r3) with 0 waits, rf r0=5, r3=7 -> alu_a=5, alu_b=7; in WB rf_we=1, rf_waddr=3, rf_wdata=alu_result=12; pc=1.
- Fetch with 3 wait states -> mem_req high for 4 cycles with addr stable; exactly one pc increment; mem_req falls the cycle after ack.
- CMP (0x6...) -> psr_we=1 in WB, rf_we never asserted.
- BRA cc=2 target 0x0A0: with psr_q[1]=1 -> next fetch addr 0x0A0; with psr_q=0 -> next fetch addr pc+1; cc=0 is always taken.
- STR imm 0x3800_5010 -> mem_we=1, mem_addr=0x010, mem_wdata=0x005. LD direct 0x2002_0004 with mem data 0xDEAD -> rf_waddr=4, rf_wdata=0xDEAD.
- Timeout and halt/trap:
  - MEM_TIMEOUT=4, no ack -> trap=1, cause=10 after 4 req cycles; only reset recovers.
  - Opcode 0xF -> trap with cause 01.
  - HLT -> halted=1; resume pulse -> next fetch at following pc.
  - reset low mid-handshake -> mem_req=0 immediately, pc=RESET_PC.
